if_sram_bridge: RTL and testbench

Fetch-side bridge between the pre-fetch PC register stage and the decode stage. It turns each valid PC leaving pre-fetch into an instruction-SRAM request on a split address/data handshake and tracks in-flight requests in order. It buffers returned instruction words with their PCs and presents them to decode on the pipeline valid/allowin handshake. A redirect flush discards buffered words and silently drops responses to requests already in flight.

---
 rtl/if_sram_bridge.sv | 128 ++++++++++++
 tb/tb_if_sram_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_sram_bridge.sv
// if_sram_bridge
//   Fetch-side bridge between the pre-fetch PC stage and decode. Each valid PC
//   leaving pre-fetch becomes an instruction-SRAM request on a split
//   address/data handshake. PCs of live in-flight requests are kept in order,
//   returned words are buffered with their PCs, and the buffer head is
//   presented to decode. A flush empties the buffer and turns every live
//   in-flight request into a cancelled one whose data is dropped on return.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   pf_valid, pf_pc    PC offered by pre-fetch
//   pf_allowin         PC accepted this cycle (address handshake done)
//   flush              redirect; kills all younger fetch state
//   inst_req/addr      SRAM request valid / address
//   inst_addr_ok       SRAM accepts the request
//   inst_data_ok/rdata SRAM returns one word, in request order
//   fs_valid/pc/inst   head instruction offered to decode
//   ds_allowin         decode accepts the head this cycle
module if_sram_bridge #(
  parameter int unsigned MAX_PEND = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pf_valid,
  input  logic [31:0] pf_pc,
  output logic        pf_allowin,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  input  logic        ds_allowin
);

  localparam int unsigned PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;

  logic [31:0]   r_pcq     [MAX_PEND];
  logic [31:0]   r_buf_pc  [MAX_PEND];
  logic [31:0]   r_buf_inst[MAX_PEND];
  logic [PW-1:0] r_pc_wp, r_pc_rp;
  logic [PW-1:0] r_buf_wp, r_buf_rp;
  logic [2:0]    r_live;
  logic [2:0]    r_cancel;
  logic [2:0]    r_buf_cnt;

  logic [3:0]    w_occ;
  logic          w_credit;
  logic          w_fs_pop;
  logic          w_dok_any;
  logic          w_dok_live;
  logic          w_dok_drop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    f_inc = (p == PW'(MAX_PEND - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_occ = {1'b0, r_live} + {1'b0, r_cancel} + {1'b0, r_buf_cnt};

  assign fs_valid = (r_buf_cnt != 3'd0) && !flush;
  assign fs_pc    = r_buf_pc[r_buf_rp];
  assign fs_inst  = r_buf_inst[r_buf_rp];
  assign w_fs_pop = fs_valid && ds_allowin;

  // A head leaving for decode this cycle frees its slot immediately, which is
  // what lets a 2-deep bridge sustain one instruction per cycle.
  assign w_credit = (w_occ - {3'b000, w_fs_pop}) < 4'(MAX_PEND);

  // resetn gating keeps the request low while reset is held.
  assign inst_req   = resetn && pf_valid && w_credit && !flush;
  assign inst_addr  = pf_pc;
  assign pf_allowin = inst_req && inst_addr_ok;

  // data_ok with nothing outstanding is a protocol error and is ignored.
  assign w_dok_any  = inst_data_ok && ((r_live != 3'd0) || (r_cancel != 3'd0));
  assign w_dok_drop = inst_data_ok && (r_cancel != 3'd0);
  assign w_dok_live = inst_data_ok && (r_cancel == 3'd0) && (r_live != 3'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < MAX_PEND; i++) begin
        r_pcq[i]      <= '0;
        r_buf_pc[i]   <= '0;
        r_buf_inst[i] <= '0;
      end
      r_pc_wp   <= '0;
      r_pc_rp   <= '0;
      r_buf_wp  <= '0;
      r_buf_rp  <= '0;
      r_live    <= '0;
      r_cancel  <= '0;
      r_buf_cnt <= '0;
    end else if (flush) begin
      // Every live request becomes cancelled; a word returning in this very
      // cycle is charged against that cancelled total.
      r_pc_wp   <= '0;
      r_pc_rp   <= '0;
      r_buf_wp  <= '0;
      r_buf_rp  <= '0;
      r_live    <= '0;
      r_buf_cnt <= '0;
      r_cancel  <= r_cancel + r_live - 3'(w_dok_any);
    end else begin
      if (pf_allowin) begin
        r_pcq[r_pc_wp] <= pf_pc;
        r_pc_wp        <= f_inc(r_pc_wp);
      end
      if (w_dok_live) begin
        r_buf_pc[r_buf_wp]   <= r_pcq[r_pc_rp];
        r_buf_inst[r_buf_wp] <= inst_rdata;
        r_buf_wp             <= f_inc(r_buf_wp);
        r_pc_rp              <= f_inc(r_pc_rp);
      end
      if (w_dok_drop) begin
        r_cancel <= r_cancel - 3'd1;
      end
      if (w_fs_pop) begin
        r_buf_rp <= f_inc(r_buf_rp);
      end
      r_live    <= r_live + 3'(pf_allowin) - 3'(w_dok_live);
      r_buf_cnt <= r_buf_cnt + 3'(w_dok_live) - 3'(w_fs_pop);
    end
  end

endmodule

// File: tb/tb_if_sram_bridge.sv
module tb_if_sram_bridge;

  localparam int unsigned MAXP = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pf_valid;
  logic [31:0] pf_pc;
  logic        pf_allowin;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        ds_allowin;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: ordered queue of live request PCs, a count of cancelled
  // requests, and an ordered queue of delivered {pc, inst} words.
  logic [31:0] m_pcq[$];
  logic [31:0] m_opc[$];
  logic [31:0] m_oinst[$];
  int unsigned m_cancel = 0;
  bit          last_acc;

  if_sram_bridge #(.MAX_PEND(MAXP)) dut (
    .clk(clk), .resetn(resetn),
    .pf_valid(pf_valid), .pf_pc(pf_pc), .pf_allowin(pf_allowin),
    .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .ds_allowin(ds_allowin)
  );

  always #5 clk = ~clk;

  function automatic int unsigned outstanding();
    return m_pcq.size() + m_cancel;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, then
  // advance the model over the rising edge.
  task automatic cyc(input bit pfv, input logic [31:0] pc, input bit fl,
                     input bit aok, input bit dok, input logic [31:0] rd,
                     input bit dsa);
    bit          e_req, e_allow, e_fsv, pop, dec;
    int unsigned occ;
    pf_valid = pfv; pf_pc = pc; flush = fl; inst_addr_ok = aok;
    inst_data_ok = dok; inst_rdata = rd; ds_allowin = dsa;
    occ     = m_pcq.size() + m_cancel + m_opc.size();
    e_fsv   = (m_opc.size() != 0) && !fl;
    pop     = e_fsv && dsa;
    e_req   = resetn && pfv && !fl && ((occ - (pop ? 1 : 0)) < MAXP);
    e_allow = e_req && aok;
    @(negedge clk);
    total++;
    assert (inst_req === e_req) else begin
      bad++; $error("FAIL inst_req got=%0b exp=%0b t=%0t", inst_req, e_req, $time);
    end
    total++;
    assert (pf_allowin === e_allow) else begin
      bad++; $error("FAIL pf_allowin got=%0b exp=%0b t=%0t", pf_allowin, e_allow, $time);
    end
    total++;
    assert (fs_valid === e_fsv) else begin
      bad++; $error("FAIL fs_valid got=%0b exp=%0b t=%0t", fs_valid, e_fsv, $time);
    end
    if (e_req) begin
      total++;
      assert (inst_addr === pc) else begin
        bad++; $error("FAIL inst_addr got=%h exp=%h", inst_addr, pc);
      end
    end
    if (e_fsv) begin
      total++;
      assert (fs_pc === m_opc[0]) else begin
        bad++; $error("FAIL fs_pc got=%h exp=%h t=%0t", fs_pc, m_opc[0], $time);
      end
      total++;
      assert (fs_inst === m_oinst[0]) else begin
        bad++; $error("FAIL fs_inst got=%h exp=%h t=%0t", fs_inst, m_oinst[0], $time);
      end
    end
    @(posedge clk);
    if (!resetn) begin
      m_pcq.delete(); m_opc.delete(); m_oinst.delete(); m_cancel = 0;
    end else if (fl) begin
      dec = dok && (outstanding() != 0);
      m_cancel = m_cancel + m_pcq.size() - (dec ? 1 : 0);
      m_pcq.delete(); m_opc.delete(); m_oinst.delete();
    end else begin
      if (dok) begin
        if (m_cancel != 0) m_cancel--;
        else if (m_pcq.size() != 0) begin
          m_opc.push_back(m_pcq.pop_front());
          m_oinst.push_back(rd);
        end
      end
      if (pop) begin
        void'(m_opc.pop_front());
        void'(m_oinst.pop_front());
      end
      if (e_allow) m_pcq.push_back(pc);
    end
    last_acc = e_allow;
    #1;
  endtask

  task automatic check_reset_regs();
    total++;
    assert (fs_pc === 32'h0) else begin
      bad++; $error("FAIL reset_fs_pc got=%h exp=00000000", fs_pc);
    end
    total++;
    assert (fs_inst === 32'h0) else begin
      bad++; $error("FAIL reset_fs_inst got=%h exp=00000000", fs_inst);
    end
  endtask

  initial begin
    logic [31:0] cur_pc;
    bit          pv, fl, dok, dsa;
    resetn = 1'b0; pf_valid = 1'b0; pf_pc = '0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; ds_allowin = 1'b0;
    @(posedge clk); #1;

    // Reset held with a PC offered: no request may leave.
    cyc(1, 32'h1234, 0, 1, 0, 0, 0);
    cyc(1, 32'h1234, 0, 1, 0, 0, 1);
    check_reset_regs();
    resetn = 1'b1;

    // Single fetch after reset
    cyc(1, 32'hBFC00000, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h24080001, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back streaming, 1-cycle SRAM, decode always ready
    cyc(1, 32'h100, 0, 1, 0, 0, 1);
    cyc(1, 32'h104, 0, 1, 1, 32'hA0000100, 1);
    cyc(1, 32'h108, 0, 1, 1, 32'hA0000104, 1);
    cyc(0, 0, 0, 0, 1, 32'hA0000108, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Credit stall: two in flight, third PC waits for a return and a slot
    cyc(1, 32'h300, 0, 1, 0, 0, 0);
    cyc(1, 32'h304, 0, 1, 0, 0, 0);
    cyc(1, 32'h308, 0, 1, 0, 0, 0);
    cyc(1, 32'h308, 0, 1, 0, 0, 0);
    cyc(1, 32'h308, 0, 1, 1, 32'hC300, 0);
    cyc(1, 32'h308, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 32'hC304, 1);
    cyc(0, 0, 0, 0, 1, 32'hC308, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Decode backpressure with two words buffered
    cyc(1, 32'h400, 0, 1, 0, 0, 0);
    cyc(1, 32'h404, 0, 1, 1, 32'hD400, 0);
    cyc(1, 32'h408, 0, 1, 1, 32'hD404, 0);
    cyc(1, 32'h408, 0, 1, 0, 0, 0);
    cyc(1, 32'h408, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Flush with two in flight; their data must be dropped
    cyc(1, 32'h500, 0, 1, 0, 0, 1);
    cyc(1, 32'h504, 0, 1, 0, 0, 1);
    cyc(1, 32'h600, 1, 1, 0, 0, 1);
    cyc(1, 32'h200, 0, 1, 1, 32'hDEAD, 1);
    cyc(1, 32'h200, 0, 0, 1, 32'hBEEF, 1);
    cyc(1, 32'h200, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 32'h20000200, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Flush coinciding with data_ok and pf_valid while a word is buffered
    cyc(1, 32'h700, 0, 1, 0, 0, 0);
    cyc(1, 32'h704, 0, 1, 1, 32'hE700, 0);
    cyc(1, 32'h708, 1, 1, 1, 32'hE704, 1);
    cyc(1, 32'h708, 0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 32'hE708, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Stray data_ok with nothing outstanding is ignored
    cyc(0, 0, 0, 0, 1, 32'hBAD0BAD0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic, with a reset in the middle
    cur_pc = 32'h1000;
    pv = 0;
    for (int i = 0; i < 400; i++) begin
      resetn = (i != 200);
      if (!pv) pv = ($urandom_range(3) != 0);
      fl  = ($urandom_range(15) == 0);
      dok = (outstanding() != 0) && ($urandom_range(2) != 0);
      dsa = ($urandom_range(3) != 0);
      cyc(pv, cur_pc, fl, $urandom_range(1) == 1, dok, $urandom, dsa);
      if (i == 200) check_reset_regs();
      if (last_acc || fl || i == 200) begin
        cur_pc = {$urandom_range(32'h3FFFFFFF), 2'b00};
        pv = 0;
      end
    end
    resetn = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
